uart_tx_arb: RTL
================

UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter N_REQ, default 4: number of byte requesters (2..8).
REQ-002 Parameter DATA_W, default 8: byte width.
REQ-003 Parameter TIMEOUT, default 512: maximum cycles from tx_start to tx_done before the transfer is abandoned (16..1023).
REQ-004 clk  input  1  system clock; all logic on posedge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 req  input  N_REQ  per-requester byte-pending flag; held until the matching ack.
REQ-007 req_data  input  N_REQ*DATA_W  flattened bytes; requester k occupies bits [k*DATA_W +: DATA_W]; stable while req[k]=1.
REQ-008 ack  output  N_REQ  one-cycle pulse; byte of requester k taken.
REQ-009 grant  output  N_REQ  one-hot owner of the transmitter; all-zero when idle.
REQ-010 tx_start  output  1  one-cycle launch pulse to the UART transmitter.
REQ-011 tx_data  output  DATA_W  byte to the transmitter; valid from the tx_start cycle until the transfer ends.
REQ-012 tx_busy  input  1  transmitter occupied.
REQ-013 tx_done  input  1  one-cycle pulse: stop bit finished.
REQ-014 arb_busy  output  1  high in any state other than IDLE.
REQ-015 timeout_err  output  1  one-cycle pulse when a transfer is abandoned.

Function
REQ-016 The FSM SHALL have the states IDLE, LAUNCH and WAIT_DONE.
REQ-017 IDLE: if any req bit is 1 and tx_busy=0, the block SHALL select winner w, register grant[w]=1 and tx_data=req_data[w], and go to LAUNCH; otherwise it SHALL stay in IDLE.
REQ-018 LAUNCH: the block SHALL assert tx_start=1 and ack[w]=1 for exactly this cycle, clear the timeout counter, and go to WAIT_DONE.
REQ-019 WAIT_DONE: when tx_done=1, the block SHALL go to IDLE, clear grant and update the pointer; otherwise the counter SHALL increment.
REQ-020 WAIT_DONE: if the counter reaches TIMEOUT-1 without tx_done, the block SHALL pulse timeout_err, clear grant, update the pointer and go to IDLE.
REQ-021 Latency: the first req in an idle system SHALL produce tx_start 2 cycles later (the req cycle plus the LAUNCH cycle).
REQ-022 Round-robin: the search SHALL start at index ptr and ascend with wrap (N_REQ-1 -> 0); after a grant to w, ptr SHALL become (w+1) mod N_REQ.
REQ-023 tx_done in the same cycle as a new req: the block SHALL go to IDLE first, and arbitration SHALL occur no earlier than the next cycle (one IDLE cycle minimum between transfers).
REQ-024 A req deasserted after its ack SHALL have no effect on the current transfer.
REQ-025 req[w] still high after its ack SHALL be treated as a new byte and compete normally.
REQ-026 tx_done received in IDLE or LAUNCH SHALL be ignored.
REQ-027 tx_busy=1 in IDLE SHALL block arbitration, with no ack issued.
REQ-028 At most one ack bit SHALL be high in any cycle, and ack SHALL never be high outside LAUNCH.

Reset
REQ-029 With rst=1 at a clock edge, the block SHALL set: state IDLE, ptr 0, grant 0, ack 0, tx_start 0, tx_data 0, arb_busy 0, timeout_err 0, counter 0.
REQ-030 Reset mid-transfer SHALL abandon the transfer without timeout_err.
REQ-031 The in-flight byte SHALL NOT be re-acked after a mid-transfer reset.
REQ-032 The transmitter SHALL NOT be signalled on reset; its own reset governs it.

Configuration
REQ-033 Macro UART_TX_ARB_FIXED_PRIO_EN defined: the lowest asserted req index SHALL always win; ptr SHALL be removed and held at 0.
REQ-034 Macro UART_TX_ARB_FIXED_PRIO_EN undefined: round-robin arbitration SHALL be as in REQ-022.

Verification
REQ-035 Single request: req=4'b0100, data2=8'hA5, idle -> tx_start and ack=4'b0100 2 cycles later, tx_data=8'hA5, grant=4'b0100 until tx_done.
REQ-036 Round-robin: req=4'b1111 held, tx_done returned 160 cycles after each tx_start -> ack order 0,1,2,3,0.
REQ-037 Fixed priority (macro defined), same stimulus as REQ-036 -> requester 0 acked every transfer.
REQ-038 Timeout: req=4'b0001, tx_done never pulsed -> timeout_err exactly 512 cycles after tx_start, grant=0, next grant goes to requester 1 if req[1]=1.
REQ-039 Boundary: tx_busy=1 externally with req=4'b0010 -> no ack; tx_busy falls -> tx_start 2 cycles later. tx_done coincident with a new req -> exactly one IDLE cycle between transfers.
REQ-040 Reset mid-transfer: rst for 1 cycle 50 cycles after tx_start -> all outputs 0 on the next cycle; req still high -> fresh arbitration with ptr=0.

Source files
------------

// File: rtl/uart_tx_arb.sv
// uart_tx_arb
//   Arbitrates N_REQ byte requesters onto a single UART transmitter. A pending
//   requester is granted when the transmitter is idle. The grant launches one byte
//   with a tx_start/ack pulse and is held until tx_done or until the timeout expires.
//
// Ports
//   clk          system clock, all logic on posedge
//   rst          synchronous active-high reset
//   req          per-requester byte-pending flags
//   req_data     flattened bytes, requester k at [k*DATA_W +: DATA_W]
//   ack          one-cycle pulse, byte of the granted requester taken
//   grant        one-hot transmitter owner, zero when idle
//   tx_start     one-cycle launch pulse to the transmitter
//   tx_data      byte to the transmitter, held for the whole transfer
//   tx_busy      transmitter occupied (blocks arbitration)
//   tx_done      one-cycle pulse, stop bit finished
//   arb_busy     high whenever the FSM is not in IDLE
//   timeout_err  one-cycle pulse when a transfer is abandoned
//
// Build option
//   UART_TX_ARB_FIXED_PRIO_EN  defined: the lowest asserted req index always wins
//                              and the round-robin pointer is removed (held at 0).
//                              undefined: round-robin starting at ptr.
module uart_tx_arb #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 512
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        ack,
  output logic [N_REQ-1:0]        grant,
  output logic                    tx_start,
  output logic [DATA_W-1:0]       tx_data,
  input  logic                    tx_busy,
  input  logic                    tx_done,
  output logic                    arb_busy,
  output logic                    timeout_err
);

  // state     | meaning
  // IDLE      | no transfer; arbitrate when a req is pending and tx_busy=0
  // LAUNCH    | tx_start and ack pulse for the granted requester
  // WAIT_DONE | byte in flight; wait for tx_done or timeout
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE} state_e;

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  state_e            state_q;
  logic [N_REQ-1:0]  grant_q, ack_q;
  logic              tx_start_q, arb_busy_q, timeout_err_q;
  logic [DATA_W-1:0] tx_data_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  ptr_q, win_idx;
  logic              win_vld;
  logic [DATA_W-1:0] win_data;

`ifdef UART_TX_ARB_FIXED_PRIO_EN
  assign ptr_q = '0;
`else
  logic [IDX_W-1:0] own_q, ptr_d;
  assign ptr_d = (own_q == IDX_W'(N_REQ-1)) ? '0 : own_q + 1'b1;
`endif

  // Scan offsets from the far end down so the lowest offset from ptr wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = N_REQ-1; k >= 0; k--) begin
      if (req[IDX_W'((int'(ptr_q) + k) % N_REQ)]) begin
        win_vld = 1'b1;
        win_idx = IDX_W'((int'(ptr_q) + k) % N_REQ);
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_idx == IDX_W'(i)) win_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  assign cnt_d = cnt_q + 1'b1;

  // Outputs are registered on the edge that enters a state, so tx_start/ack
  // are high exactly during LAUNCH. The transmitter is never signalled on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      ack_q         <= '0;
      tx_start_q    <= 1'b0;
      tx_data_q     <= '0;
      arb_busy_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      cnt_q         <= '0;
`ifndef UART_TX_ARB_FIXED_PRIO_EN
      ptr_q         <= '0;
      own_q         <= '0;
`endif
    end else begin
      ack_q         <= '0;
      tx_start_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (win_vld && !tx_busy) begin
            grant_q    <= ONE << win_idx;
            ack_q      <= ONE << win_idx;
            tx_start_q <= 1'b1;
            tx_data_q  <= win_data;
            arb_busy_q <= 1'b1;
            state_q    <= LAUNCH;
`ifndef UART_TX_ARB_FIXED_PRIO_EN
            own_q      <= win_idx;
`endif
          end
        end
        LAUNCH: begin
          cnt_q   <= '0;
          state_q <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (tx_done) begin
            grant_q    <= '0;
            arb_busy_q <= 1'b0;
            state_q    <= IDLE;
`ifndef UART_TX_ARB_FIXED_PRIO_EN
            ptr_q      <= ptr_d;
`endif
          end else if (cnt_d == CNT_W'(TIMEOUT-1)) begin
            grant_q       <= '0;
            arb_busy_q    <= 1'b0;
            timeout_err_q <= 1'b1;
            state_q       <= IDLE;
`ifndef UART_TX_ARB_FIXED_PRIO_EN
            ptr_q         <= ptr_d;
`endif
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack         = ack_q;
  assign grant       = grant_q;
  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign arb_busy    = arb_busy_q;
  assign timeout_err = timeout_err_q;

endmodule
